// File: rtl/seven_segment_scanner_if.sv
// Bus between the value-producing datapath and the 7-segment scanner.
// master = datapath side, slave = scanner side.
interface seven_segment_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_lz;
   logic                    enable;
   logic [6:0]              cathodes;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   anodes;
   logic                    update_pending;
   logic                    frame_tick;

   modport master (
      output load, value, dp_in, blank_lz, enable,
      input  cathodes, dp, anodes, update_pending, frame_tick
   );

   modport slave (
      input  load, value, dp_in, blank_lz, enable,
      output cathodes, dp, anodes, update_pending, frame_tick
   );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode hex display driver. Values are staged in a
// pending buffer and copied to the display buffer only at a frame boundary,
// so a frame never mixes old and new digits.
module seven_segment_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 100
) (
   input logic                   clock,
   input logic                   reset,
   seven_segment_scanner_if.slave bus
);
   localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
   logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
   logic                    pending;
   logic                    tick_q;
   logic [6:0]              cath_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;

   logic                    slot_end, frame_end, in_blank;
   logic [NUM_DIGITS:0]     zero_from;
   logic [3:0]              cur_dig;
   logic                    cur_dp, cur_zero, lz_hit;

   // Segment patterns ABCDEFG, active-low.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b0000001;
         4'h1: seg7 = 7'b1001111;
         4'h2: seg7 = 7'b0010010;
         4'h3: seg7 = 7'b0000110;
         4'h4: seg7 = 7'b1001100;
         4'h5: seg7 = 7'b0100100;
         4'h6: seg7 = 7'b0100000;
         4'h7: seg7 = 7'b0001111;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0000100;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b1100000;
         4'hC: seg7 = 7'b0110001;
         4'hD: seg7 = 7'b1000010;
         4'hE: seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
   assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
   assign in_blank  = (cnt < CW'(BLANK_CYCLES));

   // zero_from[k] = digit k and every digit above it are zero.
   assign zero_from[NUM_DIGITS] = 1'b1;
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
      assign zero_from[k] = zero_from[k+1] && (disp_val[4*k +: 4] == 4'h0);
   end

   // Select the digit currently being scanned out of the display buffer.
   always_comb begin
      cur_dig  = 4'h0;
      cur_dp   = 1'b0;
      cur_zero = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_dig  = disp_val[4*k +: 4];
            cur_dp   = disp_dp[k];
            cur_zero = zero_from[k];
         end
      end
   end

   // Digit 0 always shows, even when the whole value is zero.
   assign lz_hit = bus.blank_lz && (idx != '0) && cur_zero;

   // Slot counter and digit index.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Double buffer: load fills pending; frame boundary moves the pre-edge
   // pending contents to display. A load on the boundary keeps pending set.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_val <= '0;
         pend_dp  <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
         pending  <= 1'b0;
      end else begin
         if (frame_end && pending) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         if (bus.load) begin
            pend_val <= bus.value;
            pend_dp  <= bus.dp_in;
            pending  <= 1'b1;
         end else if (frame_end) begin
            pending  <= 1'b0;
         end
      end
   end

   // Registered outputs, one cycle behind the counter/index state.
   always_ff @(posedge clock) begin
      if (reset) begin
         cath_q <= 7'b1111111;
         dp_q   <= 1'b1;
         an_q   <= '1;
         tick_q <= 1'b0;
      end else begin
         cath_q <= lz_hit ? 7'b1111111 : seg7(cur_dig);
         dp_q   <= ~cur_dp;
         an_q   <= (in_blank || !bus.enable) ? '1 : ~(NUM_DIGITS'(1) << idx);
         tick_q <= frame_end;
      end
   end

   assign bus.cathodes       = cath_q;
   assign bus.dp             = dp_q;
   assign bus.anodes         = an_q;
   assign bus.update_pending = pending;
   assign bus.frame_tick     = tick_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: a 4-digit and a 1-digit instance share
// the same stimulus and are each checked every cycle against a reference
// model of the display rules.
module tb_seven_segment_scanner;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   seven_segment_scanner_if #(.NUM_DIGITS(4)) i1 ();
   seven_segment_scanner_if #(.NUM_DIGITS(1)) i2 ();

   seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2))
      dut1 (.clock(clock), .reset(reset), .bus(i1));
   seven_segment_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(2), .BLANK_CYCLES(0))
      dut2 (.clock(clock), .reset(reset), .bus(i2));

   // Shared stimulus.
   logic        load, blz, en;
   logic [15:0] val;
   logic [3:0]  dpi;

   assign i1.load = load;  assign i1.value = val;      assign i1.dp_in = dpi;
   assign i1.blank_lz = blz; assign i1.enable = en;
   assign i2.load = load;  assign i2.value = val[3:0]; assign i2.dp_in = dpi[0];
   assign i2.blank_lz = blz; assign i2.enable = en;

   logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   typedef struct {
      int          cnt, idx;
      logic [15:0] pend, disp;
      logic [3:0]  pdp, ddp;
      logic        up;
      logic [6:0]  cath;
      logic        dpo;
      int          an;
      logic        ft;
   } mst_t;

   mst_t m1, m2;

   // One clock of the reference: outputs from the pre-edge state, then
   // buffer/counter update.
   function automatic mst_t step(mst_t s, int nd, int rd, int bc, logic rst,
                                 logic ld, logic [15:0] v, logic [3:0] dv,
                                 logic bl, logic e);
      mst_t n = s;
      int   amask = (1 << nd) - 1;
      logic [15:0] vmask = (nd >= 4) ? 16'hFFFF : 16'((1 << (4*nd)) - 1);
      logic [15:0] upper;
      bit   bnd;
      if (rst) begin
         n = '{default: 0};
         n.cath = 7'h7F; n.dpo = 1'b1; n.an = amask;
         return n;
      end
      upper  = s.disp >> (4*s.idx);
      n.cath = (bl && s.idx > 0 && upper == 0) ? 7'h7F : SEG[upper[3:0]];
      n.dpo  = ~s.ddp[s.idx];
      n.an   = (s.cnt < bc || !e) ? amask : (amask & ~(1 << s.idx));
      bnd    = (s.cnt == rd-1) && (s.idx == nd-1);
      n.ft   = bnd;
      if (bnd && s.up) begin n.disp = s.pend; n.ddp = s.pdp; n.up = 0; end
      if (ld) begin n.pend = v & vmask; n.pdp = dv & 4'(amask); n.up = 1; end
      n.cnt = (s.cnt + 1) % rd;
      if (n.cnt == 0) n.idx = (s.idx + 1) % nd;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      m1 = step(m1, 4, 8, 2, reset, load, val, dpi, blz, en);
      m2 = step(m2, 1, 2, 0, reset, load, val, dpi, blz, en);
      #1;
      chk("cath4", 32'(i1.cathodes), 32'(m1.cath));
      chk("dp4",   32'(i1.dp),       32'(m1.dpo));
      chk("an4",   32'(i1.anodes),   m1.an);
      chk("upd4",  32'(i1.update_pending), 32'(m1.up));
      chk("tick4", 32'(i1.frame_tick), 32'(m1.ft));
      chk("cath1", 32'(i2.cathodes), 32'(m2.cath));
      chk("dp1",   32'(i2.dp),       32'(m2.dpo));
      chk("an1",   32'(i2.anodes),   m2.an);
      chk("upd1",  32'(i2.update_pending), 32'(m2.up));
      chk("tick1", 32'(i2.frame_tick), 32'(m2.ft));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load = 1'b1; val = v; dpi = d;
      tick();
      load = 1'b0;
   endtask

   initial begin
      int g;
      m1 = '{default: 0};
      m2 = '{default: 0};
      reset = 1'b1; load = 1'b0; blz = 1'b0; en = 1'b0; val = '0; dpi = '0;
      run(2);
      chk("rst_an",   32'(i1.anodes), 32'hF);
      chk("rst_cath", 32'(i1.cathodes), 32'h7F);

      // Free-running scan with the cleared display buffer.
      reset = 1'b0; en = 1'b1;
      run(40);

      // Mid-frame load, shown from the next frame on.
      run(5);
      do_load(16'h3A0F, 4'b0100);
      chk("pend_set", 32'(i1.update_pending), 32'h1);
      run(70);

      // Leading-zero blanking on and off.
      do_load(16'h0050, 4'b0000);
      blz = 1'b1;
      run(70);
      blz = 1'b0;
      run(40);

      // Overwritten pending value never reaches the display.
      do_load(16'h1111, 4'b0001);
      run(3);
      do_load(16'h2222, 4'b0010);
      run(70);

      // Load exactly on the boundary cycle.
      do_load(16'h4444, 4'b0000);
      g = 0;
      while (g < 100 && !(m1.cnt == 7 && m1.idx == 3)) begin tick(); g++; end
      chk("bnd_reach", 32'(g < 100), 32'h1);
      do_load(16'h5555, 4'b1000);
      chk("bnd_pend", 32'(i1.update_pending), 32'h1);
      run(70);

      // Display off while frames keep ticking.
      en = 1'b0;
      run(70);
      en = 1'b1;

      // Reset in the middle of digit 2's slot.
      g = 0;
      while (g < 100 && !(m1.idx == 2 && m1.cnt == 4)) begin tick(); g++; end
      chk("mid_reach", 32'(g < 100), 32'h1);
      reset = 1'b1;
      tick();
      chk("mid_rst_an", 32'(i1.anodes), 32'hF);
      reset = 1'b0;
      run(40);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         load  = ($urandom_range(0, 11) == 0);
         val   = 16'($urandom);
         if ($urandom_range(0, 1) == 0) val[15:8] = 8'h00;
         dpi   = 4'($urandom);
         if ($urandom_range(0, 29) == 0) blz = ~blz;
         if ($urandom_range(0, 29) == 0) en  = ~en;
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0; load = 1'b0;
      run(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
